// File: rtl/uart_pkg.sv
// Shared UART constants: queue defaults, TX FSM encoding and ASCII codes.
package uart_pkg;

  localparam int unsigned BYTE_W           = 8;
  localparam int unsigned DEPTH_DEF        = 8;
  localparam int unsigned ADDR_W_DEF       = 3;
  localparam int unsigned BUSY_TIMEOUT_DEF = 16;
  localparam int unsigned TMO_W            = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_BUSY = 2'd1,
    ST_WAIT_DONE = 2'd2
  } tx_state_e;

  localparam logic [BYTE_W-1:0] ASCII_0  = 8'h30;
  localparam logic [BYTE_W-1:0] ASCII_A  = 8'h41;
  localparam logic [BYTE_W-1:0] ASCII_SP = 8'h20;
  localparam logic [BYTE_W-1:0] ASCII_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] ASCII_LF = 8'h0A;

endpackage

// File: rtl/uart_tx_queue_fifo_sync_mem.sv
// Synchronous byte FIFO: storage, wrap-around pointers and occupancy count.
module fifo_sync_mem
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH  = DEPTH_DEF,
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk_60mhz,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_pop,
  input  logic              i_flush,
  output logic [BYTE_W-1:0] o_rd_data,
  output logic              o_full,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count
);

  logic [BYTE_W-1:0] r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              w_push_ok;
  logic              w_pop_ok;

  // Full/empty come from the pre-edge count, so a same-cycle pop never makes room
  assign o_full    = (r_count == (ADDR_W+1)'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_count   = r_count;
  assign o_rd_data = r_mem[r_rd_ptr];
  assign w_push_ok = i_push & ~o_full  & ~i_flush;
  assign w_pop_ok  = i_pop  & ~o_empty & ~i_flush;

  // Storage write; contents need no reset since pointers define validity
  always_ff @(posedge clk_60mhz) begin
    if (w_push_ok) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Pointers and count; flush empties the queue
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push_ok) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + ADDR_W'(1);
      case ({w_push_ok, w_pop_ok})
        2'b10:   r_count <= r_count + (ADDR_W+1)'(1);
        2'b01:   r_count <= r_count - (ADDR_W+1)'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter, paced by the tx_busy handshake.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int unsigned DEPTH        = DEPTH_DEF,
  parameter int unsigned ADDR_W       = ADDR_W_DEF,
  parameter int unsigned BUSY_TIMEOUT = BUSY_TIMEOUT_DEF
) (
  input  logic              clk_60mhz,
  input  logic              rst,
  input  logic              i_wr_pulse,
  input  logic [BYTE_W-1:0] i_wr_data,
  input  logic              i_flush,
  input  logic              i_tx_busy,
  output logic              o_tx_en,
  output logic [BYTE_W-1:0] o_tx_data,
  output logic [ADDR_W:0]   o_count,
  output logic              o_empty,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_timeout_err
);

  tx_state_e         r_state;
  tx_state_e         w_state_n;
  logic              r_tx_en;
  logic              w_tx_en_n;
  logic [BYTE_W-1:0] r_tx_data;
  logic [BYTE_W-1:0] w_tx_data_n;
  logic [TMO_W-1:0]  r_tmo;
  logic [TMO_W-1:0]  w_tmo_n;
  logic              r_overflow;
  logic              w_overflow_n;
  logic              r_timeout_err;
  logic              w_timeout_err_n;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [BYTE_W-1:0] w_rd_data;

  fifo_sync_mem #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk_60mhz (clk_60mhz),
    .rst       (rst),
    .i_push    (i_wr_pulse),
    .i_wr_data (i_wr_data),
    .i_pop     (w_pop),
    .i_flush   (i_flush),
    .o_rd_data (w_rd_data),
    .o_full    (w_full),
    .o_empty   (w_empty),
    .o_count   (o_count)
  );

  assign o_tx_en       = r_tx_en;
  assign o_tx_data     = r_tx_data;
  assign o_empty       = w_empty;
  assign o_full        = w_full;
  assign o_overflow    = r_overflow;
  assign o_timeout_err = r_timeout_err;

  // Send FSM next-state plus sticky error flags
  always_comb begin
    w_state_n       = r_state;
    w_tx_en_n       = 1'b0;
    w_tx_data_n     = r_tx_data;
    w_tmo_n         = r_tmo;
    w_pop           = 1'b0;
    w_overflow_n    = r_overflow;
    w_timeout_err_n = r_timeout_err;

    case (r_state)
      ST_IDLE: begin
        if (!w_empty && !i_tx_busy && !i_flush) begin
          w_tx_data_n = w_rd_data;
          w_pop       = 1'b1;
          w_tx_en_n   = 1'b1;
          w_tmo_n     = '0;
          w_state_n   = ST_WAIT_BUSY;
        end
      end
      ST_WAIT_BUSY: begin
        if (i_tx_busy) begin
          w_state_n = ST_WAIT_DONE;
        end else if (r_tmo == TMO_W'(BUSY_TIMEOUT - 1)) begin
          w_timeout_err_n = 1'b1;
          w_state_n       = ST_IDLE;
        end else begin
          w_tmo_n = r_tmo + TMO_W'(1);
        end
      end
      ST_WAIT_DONE: begin
        if (!i_tx_busy) begin
          w_state_n = ST_IDLE;
        end
      end
      default: w_state_n = ST_IDLE;
    endcase

    // Flush clears the sticky flags and swallows any same-cycle write
    if (i_flush) begin
      w_overflow_n    = 1'b0;
      w_timeout_err_n = 1'b0;
    end else if (i_wr_pulse && w_full) begin
      w_overflow_n = 1'b1;
    end
  end

  // State and output registers
  always_ff @(posedge clk_60mhz or posedge rst) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_tx_en       <= 1'b0;
      r_tx_data     <= '0;
      r_tmo         <= '0;
      r_overflow    <= 1'b0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_n;
      r_tx_en       <= w_tx_en_n;
      r_tx_data     <= w_tx_data_n;
      r_tmo         <= w_tmo_n;
      r_overflow    <= w_overflow_n;
      r_timeout_err <= w_timeout_err_n;
    end
  end

endmodule

// File: tb/tb_uart_tx_queue.sv
// Scoreboard bench for uart_tx_queue with a simple transmitter busy model.
module tb_uart_tx_queue;

  localparam int unsigned DEPTH  = 8;
  localparam int unsigned ADDR_W = 3;
  localparam int unsigned TMO    = 16;

  logic              clk_60mhz = 1'b0;
  logic              rst       = 1'b1;
  logic              i_wr_pulse = 1'b0;
  logic [7:0]        i_wr_data  = 8'h00;
  logic              i_flush    = 1'b0;
  logic              i_tx_busy  = 1'b0;
  logic              o_tx_en;
  logic [7:0]        o_tx_data;
  logic [ADDR_W:0]   o_count;
  logic              o_empty;
  logic              o_full;
  logic              o_overflow;
  logic              o_timeout_err;

  int total = 0;
  int bad   = 0;

  logic [7:0] exp_q[$];
  logic [7:0] sent_q[$];
  int en_cnt = 0;

  // 0: busy tied low, 1: busy tied high, 2: busy rises 2 cycles after tx_en for busy_hold cycles
  int busy_mode = 0;
  int busy_hold = 5;
  int dly  = 0;
  int hold = 0;

  uart_tx_queue #(
    .DEPTH        (DEPTH),
    .ADDR_W       (ADDR_W),
    .BUSY_TIMEOUT (TMO)
  ) dut (
    .clk_60mhz     (clk_60mhz),
    .rst           (rst),
    .i_wr_pulse    (i_wr_pulse),
    .i_wr_data     (i_wr_data),
    .i_flush       (i_flush),
    .i_tx_busy     (i_tx_busy),
    .o_tx_en       (o_tx_en),
    .o_tx_data     (o_tx_data),
    .o_count       (o_count),
    .o_empty       (o_empty),
    .o_full        (o_full),
    .o_overflow    (o_overflow),
    .o_timeout_err (o_timeout_err)
  );

  always #8 clk_60mhz = ~clk_60mhz;

  // Capture sent bytes and drive the transmitter busy model on the falling edge
  always @(negedge clk_60mhz) begin
    if (!rst && o_tx_en) begin
      sent_q.push_back(o_tx_data);
      en_cnt = en_cnt + 1;
    end
    if (busy_mode == 2) begin
      if (!rst && o_tx_en) begin
        dly = 2;
      end else if (dly > 0) begin
        dly = dly - 1;
        if (dly == 0) hold = busy_hold;
      end else if (hold > 0) begin
        hold = hold - 1;
      end
      i_tx_busy = (hold > 0);
    end else begin
      dly  = 0;
      hold = 0;
      i_tx_busy = (busy_mode == 1);
    end
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk_60mhz);
    #1;
  endtask

  task automatic do_reset;
    busy_mode  = 0;
    i_wr_pulse = 1'b0;
    i_flush    = 1'b0;
    rst        = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    tick();
    exp_q.delete();
  endtask

  task automatic write_byte(input logic [7:0] b, input bit will_send);
    i_wr_pulse = 1'b1;
    i_wr_data  = b;
    if (will_send) exp_q.push_back(b);
    tick();
    i_wr_pulse = 1'b0;
  endtask

  task automatic test_reset;
    do_reset();
    total++;
    if ({o_tx_en, o_tx_data, o_count, o_empty, o_full, o_overflow, o_timeout_err} !==
        {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL reset_values: got en=%b data=%h cnt=%0d e=%b f=%b ov=%b to=%b, want 0 00 0 1 0 0 0",
               o_tx_en, o_tx_data, o_count, o_empty, o_full, o_overflow, o_timeout_err);
    end
  endtask

  task automatic test_single;
    int base;
    int en0;
    int rd;
    bit ok;
    logic [7:0] e;
    do_reset();
    base = sent_q.size();
    en0  = en_cnt;
    busy_mode = 2;
    busy_hold = 100;
    tick();
    write_byte(8'h35, 1'b1);
    total++;
    if (o_tx_en !== 1'b0 || o_count !== 4'd1) begin
      bad++;
      $display("FAIL single_pre: got en=%b cnt=%0d, want en=0 cnt=1", o_tx_en, o_count);
    end
    tick();
    total++;
    if ({o_tx_en, o_tx_data, o_count} !== {1'b1, 8'h35, 4'd0}) begin
      bad++;
      $display("FAIL single_txen: got en=%b data=%h cnt=%0d, want en=1 data=35 cnt=0",
               o_tx_en, o_tx_data, o_count);
    end
    tick();
    total++;
    if (o_tx_en !== 1'b0 || o_tx_data !== 8'h35) begin
      bad++;
      $display("FAIL single_pulse: got en=%b data=%h, want en=0 data=35", o_tx_en, o_tx_data);
    end
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (dly == 0 && hold == 0) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL single_wait: busy model never went idle"); end
    for (int i = 0; i < 5; i++) tick();
    total++;
    if (en_cnt - en0 != 1 || o_count !== 4'd0) begin
      bad++;
      $display("FAIL single_once: got tx_en count=%0d cnt=%0d, want 1 and 0", en_cnt - en0, o_count);
    end
    rd = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= sent_q.size()) begin
        bad++; $display("FAIL single_data: got nothing, want %h", e);
      end else if (sent_q[rd] !== e) begin
        bad++; $display("FAIL single_data: got %h, want %h", sent_q[rd], e);
      end
      rd++;
    end
  endtask

  task automatic test_burst;
    int base;
    int en0;
    int rd;
    bit ok;
    logic [7:0] e;
    do_reset();
    base = sent_q.size();
    en0  = en_cnt;
    busy_mode = 1;
    tick();
    tick();
    for (int i = 0; i < 10; i++) begin
      write_byte(8'(8'h30 + i), i < 8);
      if (i == 7) begin
        total++;
        if ({o_full, o_count, o_overflow} !== {1'b1, 4'd8, 1'b0}) begin
          bad++;
          $display("FAIL burst_full8: got full=%b cnt=%0d ov=%b, want 1 8 0", o_full, o_count, o_overflow);
        end
      end
    end
    total++;
    if ({o_full, o_count, o_overflow, o_tx_en} !== {1'b1, 4'd8, 1'b1, 1'b0} || en_cnt != en0) begin
      bad++;
      $display("FAIL burst_overflow: got full=%b cnt=%0d ov=%b sends=%0d, want 1 8 1 0",
               o_full, o_count, o_overflow, en_cnt - en0);
    end
    busy_mode = 2;
    busy_hold = 5;
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (sent_q.size() - base >= 8 && dly == 0 && hold == 0) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL burst_drain: only %0d of 8 bytes sent", sent_q.size() - base); end
    for (int i = 0; i < 20; i++) tick();
    rd = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= sent_q.size()) begin
        bad++; $display("FAIL burst_data: got nothing, want %h", e);
      end else if (sent_q[rd] !== e) begin
        bad++; $display("FAIL burst_data: got %h, want %h", sent_q[rd], e);
      end
      rd++;
    end
    total++;
    if (sent_q.size() != rd || o_count !== 4'd0) begin
      bad++;
      $display("FAIL burst_extra: got %0d bytes cnt=%0d, want %0d bytes cnt=0", sent_q.size() - base, o_count, rd - base);
    end
  endtask

  task automatic test_timeout;
    int base;
    int en0;
    int rd;
    logic [7:0] e;
    do_reset();
    base = sent_q.size();
    en0  = en_cnt;
    busy_mode = 0;
    tick();
    write_byte(8'h41, 1'b1);
    tick();
    total++;
    if (o_tx_en !== 1'b1 || o_tx_data !== 8'h41) begin
      bad++;
      $display("FAIL timeout_txen: got en=%b data=%h, want en=1 data=41", o_tx_en, o_tx_data);
    end
    for (int i = 0; i < 15; i++) tick();
    total++;
    if (o_timeout_err !== 1'b0) begin
      bad++; $display("FAIL timeout_early: got timeout_err=%b one cycle before limit, want 0", o_timeout_err);
    end
    tick();
    total++;
    if (o_timeout_err !== 1'b1 || o_count !== 4'd0) begin
      bad++;
      $display("FAIL timeout_set: got timeout_err=%b cnt=%0d, want 1 0", o_timeout_err, o_count);
    end
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (en_cnt - en0 != 1) begin
      bad++; $display("FAIL timeout_once: got %0d tx_en pulses, want 1", en_cnt - en0);
    end
    write_byte(8'h42, 1'b1);
    tick();
    total++;
    if (o_tx_en !== 1'b1 || o_tx_data !== 8'h42 || o_timeout_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_idle: got en=%b data=%h to=%b, want en=1 data=42 to=1", o_tx_en, o_tx_data, o_timeout_err);
    end
    for (int i = 0; i < 20; i++) tick();
    rd = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= sent_q.size()) begin
        bad++; $display("FAIL timeout_data: got nothing, want %h", e);
      end else if (sent_q[rd] !== e) begin
        bad++; $display("FAIL timeout_data: got %h, want %h", sent_q[rd], e);
      end
      rd++;
    end
  endtask

  task automatic test_flush;
    int base;
    int en0;
    int rd;
    bit ok;
    logic [7:0] e;
    do_reset();
    base = sent_q.size();
    en0  = en_cnt;
    busy_mode = 2;
    busy_hold = 30;
    tick();
    write_byte(8'h50, 1'b1);
    for (int i = 0; i < 5; i++) write_byte(8'(8'h51 + i), 1'b0);
    total++;
    if (o_count !== 4'd5) begin
      bad++; $display("FAIL flush_pre: got cnt=%0d, want 5", o_count);
    end
    i_flush    = 1'b1;
    i_wr_pulse = 1'b1;
    i_wr_data  = 8'hEE;
    tick();
    i_flush    = 1'b0;
    i_wr_pulse = 1'b0;
    total++;
    if ({o_count, o_empty, o_overflow} !== {4'd0, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL flush_clear: got cnt=%0d empty=%b ov=%b, want 0 1 0", o_count, o_empty, o_overflow);
    end
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      if (dly == 0 && hold == 0) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL flush_wait: busy model never went idle"); end
    for (int i = 0; i < 20; i++) tick();
    total++;
    if (en_cnt - en0 != 1 || o_timeout_err !== 1'b0) begin
      bad++;
      $display("FAIL flush_nosend: got %0d pulses to=%b, want 1 pulse to=0", en_cnt - en0, o_timeout_err);
    end
    write_byte(8'h56, 1'b1);
    for (int i = 0; i < 60; i++) tick();
    rd = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= sent_q.size()) begin
        bad++; $display("FAIL flush_data: got nothing, want %h", e);
      end else if (sent_q[rd] !== e) begin
        bad++; $display("FAIL flush_data: got %h, want %h", sent_q[rd], e);
      end
      rd++;
    end
    total++;
    if (sent_q.size() != rd) begin
      bad++; $display("FAIL flush_extra: got %0d bytes, want %0d", sent_q.size() - base, rd - base);
    end
  endtask

  task automatic test_wrap;
    int base;
    int rd;
    bit ok;
    logic [7:0] e;
    do_reset();
    base = sent_q.size();
    busy_mode = 1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) write_byte(8'(8'h60 + i), 1'b1);
    total++;
    if (o_count !== 4'd3) begin
      bad++; $display("FAIL wrap_pre: got cnt=%0d, want 3", o_count);
    end
    busy_mode = 2;
    busy_hold = 2;
    write_byte(8'h63, 1'b1);
    total++;
    if (o_count !== 4'd3 || o_tx_en !== 1'b1 || o_tx_data !== 8'h60) begin
      bad++;
      $display("FAIL wrap_simul: got cnt=%0d en=%b data=%h, want cnt=3 en=1 data=60", o_count, o_tx_en, o_tx_data);
    end
    for (int i = 4; i < 20; i++) begin
      for (int g = 0; g < 8 + (i % 5) * 2; g++) tick();
      write_byte(8'(8'h60 + i), 1'b1);
    end
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      if (sent_q.size() - base >= 20 && dly == 0 && hold == 0) begin ok = 1'b1; break; end
      tick();
    end
    total++;
    if (!ok) begin bad++; $display("FAIL wrap_drain: only %0d of 20 bytes sent", sent_q.size() - base); end
    for (int i = 0; i < 10; i++) tick();
    rd = base;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++;
      if (rd >= sent_q.size()) begin
        bad++; $display("FAIL wrap_data: got nothing, want %h", e);
      end else if (sent_q[rd] !== e) begin
        bad++; $display("FAIL wrap_data: got %h, want %h", sent_q[rd], e);
      end
      rd++;
    end
    total++;
    if (sent_q.size() != rd || o_overflow !== 1'b0 || o_count !== 4'd0) begin
      bad++;
      $display("FAIL wrap_end: got %0d bytes ov=%b cnt=%0d, want %0d bytes ov=0 cnt=0",
               sent_q.size() - base, o_overflow, o_count, rd - base);
    end
  endtask

  task automatic test_reset_mid;
    int en0;
    do_reset();
    busy_mode = 2;
    busy_hold = 50;
    tick();
    write_byte(8'h70, 1'b0);
    for (int i = 0; i < 4; i++) write_byte(8'(8'h71 + i), 1'b0);
    for (int i = 0; i < 4; i++) tick();
    total++;
    if (o_count !== 4'd4) begin
      bad++; $display("FAIL rstmid_pre: got cnt=%0d, want 4", o_count);
    end
    @(negedge clk_60mhz);
    #2;
    rst = 1'b1;
    #1;
    total++;
    if ({o_tx_en, o_tx_data, o_count, o_empty, o_full, o_overflow, o_timeout_err} !==
        {1'b0, 8'h00, 4'd0, 1'b1, 1'b0, 1'b0, 1'b0}) begin
      bad++;
      $display("FAIL rstmid_async: got en=%b data=%h cnt=%0d e=%b f=%b ov=%b to=%b, want 0 00 0 1 0 0 0",
               o_tx_en, o_tx_data, o_count, o_empty, o_full, o_overflow, o_timeout_err);
    end
    busy_mode = 0;
    tick();
    tick();
    rst = 1'b0;
    en0 = en_cnt;
    for (int i = 0; i < 30; i++) tick();
    total++;
    if (en_cnt != en0 || o_count !== 4'd0 || o_empty !== 1'b1) begin
      bad++;
      $display("FAIL rstmid_quiet: got %0d pulses cnt=%0d empty=%b, want 0 0 1", en_cnt - en0, o_count, o_empty);
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_burst();
    test_timeout();
    test_flush();
    test_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
